ram_arbiter: RTL

- Two-port round-robin arbiter and access sequencer for the 32x8 asynchronous RAM (bidirectional DATA, active-high OE, active-low CS, posedge write strobe WS).
- Arbitrates between two synchronous requesters and sequences each access into a fixed 4-cycle RAM cycle.
- Generates WS, holds write data stable across the strobe edge, and guarantees bus turnaround with no contention on the shared DATA bus.
- Sits between two client blocks and one RAM instance.

---
 rtl/ram_arbiter_pkg.sv | 15 +
 rtl/ram_arbiter_rr_arb2.sv | 14 +
 rtl/ram_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: sequencer states and
// default RAM geometry.
package ram_arbiter_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-requester round-robin pick: on a tie the port that did not win last
// time is chosen, otherwise the sole requester wins.
module rr_arb2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic any_o,
  output logic win_o
);

  assign any_o = req0_i | req1_i;
  assign win_o = (req0_i & req1_i) ? ~last_i : req1_i;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and fixed 4-cycle access sequencer for a 32x8
// asynchronous RAM; every RAM-facing signal, GNT, DONE and RDATA is a flop.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WE0,
  input  logic          WE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
  output logic          GNT0,
  output logic          GNT1,
  output logic          DONE0,
  output logic          DONE1,
  output logic [DW-1:0] RDATA0,
  output logic [DW-1:0] RDATA1,
  output logic [AW-1:0] RAM_ADDR,
  inout  wire  [DW-1:0] RAM_DATA,
  output logic          RAM_OE,
  output logic          RAM_CS,
  output logic          RAM_WS
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          cs_q, cs_d;
  logic          oe_q, oe_d;
  logic          ws_q, ws_d;
  logic          drive_q, drive_d;
  logic          any_s;
  logic          win_s;

  rr_arb2 u_rr (
    .req0_i (REQ0),
    .req1_i (REQ1),
    .last_i (last_q),
    .any_o  (any_s),
    .win_o  (win_s)
  );

  // Next-state and next-output logic: outputs are computed for the state being entered.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cs_d     = cs_q;
    oe_d     = oe_q;
    ws_d     = ws_q;
    drive_d  = drive_q;
    case (state_q)
      IDLE: begin
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        ws_d    = 1'b0;
        drive_d = 1'b0;
        if (any_s) begin
          state_d        = SETUP;
          last_d         = win_s;
          port_d         = win_s;
          we_d           = win_s ? WE1 : WE0;
          addr_d         = win_s ? ADDR1 : ADDR0;
          wdata_d        = win_s ? WDATA1 : WDATA0;
          gnt_d[win_s]   = 1'b1;
          cs_d           = 1'b0;
          oe_d           = ~(win_s ? WE1 : WE0);
          drive_d        = win_s ? WE1 : WE0;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        gnt_d   = 2'b00;
        ws_d    = we_q;
        oe_d    = ~we_q;
        drive_d = we_q;
      end
      ACCESS: begin
        state_d        = FINISH;
        done_d[port_q] = 1'b1;
        ws_d           = 1'b0;
        oe_d           = 1'b0;
        // RAM output is captured on the edge that also drops OE.
        if (!we_q) begin
          if (port_q) begin
            rdata1_d = RAM_DATA;
          end else begin
            rdata0_d = RAM_DATA;
          end
        end else begin
          rdata0_d = rdata0_q;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 2'b00;
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        ws_d    = 1'b0;
        drive_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= {AW{1'b0}};
      wdata_q  <= {DW{1'b0}};
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      rdata0_q <= {DW{1'b0}};
      rdata1_q <= {DW{1'b0}};
      cs_q     <= 1'b1;
      oe_q     <= 1'b0;
      ws_q     <= 1'b0;
      drive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cs_q     <= cs_d;
      oe_q     <= oe_d;
      ws_q     <= ws_d;
      drive_q  <= drive_d;
    end
  end

  assign GNT0     = gnt_q[0];
  assign GNT1     = gnt_q[1];
  assign DONE0    = done_q[0];
  assign DONE1    = done_q[1];
  assign RDATA0   = rdata0_q;
  assign RDATA1   = rdata1_q;
  assign RAM_ADDR = addr_q;
  assign RAM_OE   = oe_q;
  assign RAM_CS   = cs_q;
  assign RAM_WS   = ws_q;
  assign RAM_DATA = drive_q ? wdata_q : {DW{1'bz}};

endmodule
